// File: rtl/lsu_pkg.sv
// Shared types and funct3 decoding for the load/store memory stage.
// Holds the FSM state encoding, width/sign codes and request legality helpers.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WRITE  = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned variants only exist for loads.
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic bad;
      case (f3)
         F3_H, F3_HU: bad = addr_lo[0];
         F3_W:        bad = (addr_lo != 2'b00);
         default:     bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction / sign extension for loads and lane merge for sub-word stores.
// Purely combinational; operates on the registered request fields.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // select the addressed byte and halfword lanes of the read word
   always_comb begin
      byte_s = 8'd0;
      case (addr_lo)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'd0;
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // extend the selected lane according to width/sign code
   always_comb begin
      load_data = 32'd0;
      case (funct3)
         F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
         F3_BU:   load_data = {24'd0, byte_s};
         F3_H:    load_data = {{16{half_s[15]}}, half_s};
         F3_HU:   load_data = {16'd0, half_s};
         F3_W:    load_data = rdata;
         default: load_data = 32'd0;
      endcase
   end

   // replace only the addressed lane of the read word with store data
   always_comb begin
      store_word = rdata;
      case (funct3)
         F3_B: begin
            case (addr_lo)
               2'd0:    store_word = {rdata[31:8], wdata[7:0]};
               2'd1:    store_word = {rdata[31:16], wdata[7:0], rdata[7:0]};
               2'd2:    store_word = {rdata[31:24], wdata[7:0], rdata[15:0]};
               2'd3:    store_word = {wdata[7:0], rdata[23:0]};
               default: store_word = rdata;
            endcase
         end
         F3_H: begin
            if (addr_lo[1]) begin
               store_word = {wdata[15:0], rdata[15:0]};
            end else begin
               store_word = {rdata[31:16], wdata[15:0]};
            end
         end
         F3_W:    store_word = wdata;
         default: store_word = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store unit: one request at a time against a
// word-wide data memory, with sub-word stores done as read-modify-write.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

   lsu_state_e  state_r, state_nxt_s;
   logic        we_r;
   logic [2:0]  funct3_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;

   logic        ready_r, rsp_valid_r, rsp_fault_r, mem_read_r, mem_write_r;
   logic [31:0] rsp_rdata_r, mem_addr_r, mem_wdata_r;

   logic        capture_s, fault_s;
   logic        rsp_valid_nxt_s, rsp_fault_nxt_s, mem_read_nxt_s, mem_write_nxt_s;
   logic [31:0] rsp_rdata_nxt_s, mem_addr_nxt_s, mem_wdata_nxt_s;
   logic [31:0] load_data_s, store_word_s;

   assign fault_s = ~funct3_legal(req_we, req_funct3)
                  | misaligned(req_funct3, req_addr[1:0])
                  | ({1'b0, req_addr} >= ADDR_LIMIT);

   lsu_align u_align (
      .funct3     (funct3_r),
      .addr_lo    (addr_r[1:0]),
      .rdata      (mem_rdata),
      .wdata      (wdata_r),
      .load_data  (load_data_s),
      .store_word (store_word_s)
   );

   // next state plus next value of every registered output
   always_comb begin
      state_nxt_s     = state_r;
      capture_s       = 1'b0;
      mem_read_nxt_s  = 1'b0;
      mem_write_nxt_s = 1'b0;
      mem_addr_nxt_s  = 32'd0;
      mem_wdata_nxt_s = 32'd0;
      rsp_valid_nxt_s = 1'b0;
      rsp_fault_nxt_s = rsp_fault_r;
      rsp_rdata_nxt_s = rsp_rdata_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               capture_s = 1'b1;
               if (fault_s) begin
                  state_nxt_s     = ST_RESP;
                  rsp_valid_nxt_s = 1'b1;
                  rsp_fault_nxt_s = 1'b1;
                  rsp_rdata_nxt_s = 32'd0;
               end else begin
                  state_nxt_s    = ST_ACCESS;
                  mem_addr_nxt_s = {req_addr[31:2], 2'b00};
                  // full-word stores skip the read and write directly
                  if (req_we && (req_funct3 == F3_W)) begin
                     mem_write_nxt_s = 1'b1;
                     mem_wdata_nxt_s = req_wdata;
                  end else begin
                     mem_read_nxt_s = 1'b1;
                  end
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (we_r && (funct3_r != F3_W)) begin
               state_nxt_s     = ST_WRITE;
               mem_write_nxt_s = 1'b1;
               mem_addr_nxt_s  = {addr_r[31:2], 2'b00};
               mem_wdata_nxt_s = store_word_s;
            end else begin
               state_nxt_s     = ST_RESP;
               rsp_valid_nxt_s = 1'b1;
               rsp_fault_nxt_s = 1'b0;
               rsp_rdata_nxt_s = we_r ? 32'd0 : load_data_s;
            end
         end
         ST_WRITE: begin
            state_nxt_s     = ST_RESP;
            rsp_valid_nxt_s = 1'b1;
            rsp_fault_nxt_s = 1'b0;
            rsp_rdata_nxt_s = 32'd0;
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // state, request capture and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         we_r        <= 1'b0;
         funct3_r    <= 3'd0;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_fault_r <= 1'b0;
         rsp_rdata_r <= 32'd0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
      end else begin
         state_r     <= state_nxt_s;
         ready_r     <= (state_nxt_s == ST_IDLE);
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_fault_r <= rsp_fault_nxt_s;
         rsp_rdata_r <= rsp_rdata_nxt_s;
         mem_read_r  <= mem_read_nxt_s;
         mem_write_r <= mem_write_nxt_s;
         mem_addr_r  <= mem_addr_nxt_s;
         mem_wdata_r <= mem_wdata_nxt_s;
         if (capture_s) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
         end else begin
            we_r     <= we_r;
            funct3_r <= funct3_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
         end
      end
   end

   assign req_ready = ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_fault = rsp_fault_r;
   assign rsp_rdata = rsp_rdata_r;
   assign mem_read  = mem_read_r;
   assign mem_write = mem_write_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus pushes expected responses and
// memory writes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_fault;
   logic [31:0] rsp_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   lsu_mem_stage #(.MEM_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [31:0] mem [0:255];
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic f; logic [31:0] d; int c; } rsp_t;
   typedef struct { logic [31:0] a; logic [31:0] d; int c; } wr_t;
   rsp_t rsp_q[$];
   wr_t  wr_q[$];

   int tests = 0, fails = 0;
   int rd_cnt = 0, wr_cnt = 0;
   bit bad_bus = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: compare responses and memory writes against the scoreboard
   always @(negedge clk) begin : mon
      rsp_t r;
      wr_t  w;
      if (rst_n === 1'b1) begin
         if (mem_read) rd_cnt++;
         if (mem_write) wr_cnt++;
         if ((mem_read && mem_write) || (!mem_read && !mem_write && mem_addr != 32'd0))
            bad_bus = 1'b1;
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL rsp_unexpected: got rsp_valid at cycle %0d, required none", cyc);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_cycle", 32'(cyc), 32'(r.c));
               chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, r.f});
               chk("rsp_rdata", rsp_rdata, r.d);
            end
         end
         if (mem_write) begin
            if (wr_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL wr_unexpected: got mem_write addr %h at cycle %0d, required none", mem_addr, cyc);
            end else begin
               w = wr_q.pop_front();
               chk("wr_cycle", 32'(cyc), 32'(w.c));
               chk("wr_addr", mem_addr, w.a);
               chk("wr_data", mem_wdata, w.d);
            end
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (rsp_q.size() == 0 && wr_q.size() == 0) break;
         @(negedge clk);
      end
      if (rsp_q.size() != 0 || wr_q.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: got %0d rsp / %0d wr pending, required 0", rsp_q.size(), wr_q.size());
         rsp_q.delete();
         wr_q.delete();
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         tests++; fails++;
         $display("FAIL ready_timeout: got req_ready %b, required 1", req_ready);
      end
   endtask

   // wlat = 0 means no memory write is expected for this request
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ef, input logic [31:0] ed,
                        input int lat, input int wlat, input logic [31:0] ewd);
      wait_ready();
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      rsp_q.push_back('{ef, ed, cyc + lat});
      if (wlat > 0) wr_q.push_back('{{addr[31:2], 2'b00}, ewd, cyc + wlat});
      @(negedge clk);
      req_valid = 1'b0;
      drain();
   endtask

   int rd0, wr0, idx;
   logic [31:0] last_sw;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_rsp", {29'd0, rsp_valid, rsp_fault, 1'b0} | rsp_rdata, 32'd0);
      chk("reset_mem_strobe", {30'd0, mem_read, mem_write}, 32'd0);
      chk("reset_mem_bus", mem_addr | mem_wdata, 32'd0);

      // preload through the DUT with full-word stores
      issue(1'b1, 3'b010, 32'h80, 32'h8899AABB, 1'b0, 32'd0, 2, 1, 32'h8899AABB);
      issue(1'b1, 3'b010, 32'h40, 32'h11223344, 1'b0, 32'd0, 2, 1, 32'h11223344);

      // loads with lane select and extension
      issue(1'b0, 3'b000, 32'h81, 32'd0, 1'b0, 32'hFFFFFFAA, 2, 0, 32'd0);
      issue(1'b0, 3'b100, 32'h81, 32'd0, 1'b0, 32'h000000AA, 2, 0, 32'd0);
      issue(1'b0, 3'b101, 32'h82, 32'd0, 1'b0, 32'h00008899, 2, 0, 32'd0);
      issue(1'b0, 3'b001, 32'h82, 32'd0, 1'b0, 32'hFFFF8899, 2, 0, 32'd0);
      issue(1'b0, 3'b010, 32'h80, 32'd0, 1'b0, 32'h8899AABB, 2, 0, 32'd0);

      // sub-word stores via read-modify-write
      issue(1'b1, 3'b000, 32'h83, 32'h00000012, 1'b0, 32'd0, 3, 2, 32'h1299AABB);
      issue(1'b0, 3'b010, 32'h80, 32'd0, 1'b0, 32'h1299AABB, 2, 0, 32'd0);
      issue(1'b1, 3'b001, 32'h80, 32'hFFFFCAFE, 1'b0, 32'd0, 3, 2, 32'h1299CAFE);
      issue(1'b0, 3'b000, 32'h80, 32'd0, 1'b0, 32'hFFFFFFFE, 2, 0, 32'd0);

      // faults: no memory traffic, response one cycle after acceptance
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue(1'b0, 3'b010, 32'h102, 32'd0, 1'b1, 32'd0, 1, 0, 32'd0);
      issue(1'b1, 3'b001, 32'h101, 32'h0000ABCD, 1'b1, 32'd0, 1, 0, 32'd0);
      issue(1'b0, 3'b010, 32'h400, 32'd0, 1'b1, 32'd0, 1, 0, 32'd0);
      issue(1'b0, 3'b011, 32'h80, 32'd0, 1'b1, 32'd0, 1, 0, 32'd0);
      issue(1'b1, 3'b100, 32'h80, 32'h00000055, 1'b1, 32'd0, 1, 0, 32'd0);
      issue(1'b0, 3'b000, 32'h400, 32'd0, 1'b1, 32'd0, 1, 0, 32'd0);
      chk("fault_no_read", 32'(rd_cnt), 32'(rd0));
      chk("fault_no_write", 32'(wr_cnt), 32'(wr0));

      // last in-range word
      issue(1'b1, 3'b010, 32'h3FC, 32'hA5A50001, 1'b0, 32'd0, 2, 1, 32'hA5A50001);
      issue(1'b0, 3'b010, 32'h3FC, 32'd0, 1'b0, 32'hA5A50001, 2, 0, 32'd0);

      // reset while an SH is in its WRITE cycle
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h40; req_wdata = 32'h00005555;
      wr_q.push_back('{32'h40, 32'h11225555, cyc + 2});
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_write_active", {31'd0, mem_write}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_write_drop", {31'd0, mem_write}, 32'd0);
      chk("rst_rsp_low", {31'd0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_word_kept", mem[16], 32'h11223344);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) @(negedge clk);
      chk("rst_no_pending_wr", 32'(wr_q.size()), 32'd0);

      // req_valid held high: alternating SW/LW, accepted only from IDLE
      wait_ready();
      idx = 0; last_sw = 32'd0;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req_we = (idx % 2 == 0);
         req_funct3 = 3'b010;
         req_addr = 32'h10;
         req_wdata = req_ready ? (32'hC0DE0000 + 32'(idx)) : (32'hBAD00000 + 32'(i));
         if (req_ready) begin
            if (req_we) begin
               rsp_q.push_back('{1'b0, 32'd0, cyc + 2});
               wr_q.push_back('{32'h10, req_wdata, cyc + 1});
               last_sw = req_wdata;
            end else begin
               rsp_q.push_back('{1'b0, last_sw, cyc + 2});
            end
            idx++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      drain();
      chk("hold_accept_count", 32'(idx), 32'd4);

      chk("bus_rules", {31'd0, bad_bus}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 256, number of 32-bit words behind the data memory port; addresses >= 4*MEM_WORDS fault.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  execute stage presents a memory request.
REQ-005 SHALL have port: req_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  output  32  extended load result; 0 for stores and faults.
REQ-012 SHALL have port: rsp_fault  output  1  misaligned, out-of-range or illegal funct3; valid with rsp_valid.
REQ-013 SHALL have port: mem_read  output  1  read strobe to word-wide data memory.
REQ-014 SHALL have port: mem_write  output  1  write strobe, sampled by memory on rising clk.
REQ-015 SHALL have port: mem_addr  output  32  word-aligned byte address (bits [1:0] = 00).
REQ-016 SHALL have port: mem_wdata  output  32  full-word write data.
REQ-017 SHALL have port: mem_rdata  input  32  combinational read data, valid same cycle as mem_read.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request on a rising edge in IDLE with req_valid = 1, registering we/funct3/addr/wdata; inputs are ignored in all other states.
REQ-020 SHALL fault when: funct3 not in {000,001,010,100,101} for loads or not in {000,001,010} for stores; H/HU with addr[0] = 1; W with addr[1:0] != 00; addr >= 4*MEM_WORDS.
REQ-021 SHALL, for a faulting request, go IDLE -> RESP with no mem_read/mem_write ever asserted; rsp_valid = 1, rsp_fault = 1 in cycle C+1 (C = acceptance cycle).
REQ-022 SHALL, for loads, assert mem_read in ACCESS (C+1), capture the lane selected by addr[1:0] (byte) or addr[1] (half), sign- or zero-extend per funct3, and pulse rsp_valid in C+2.
REQ-023 SHALL, for SW, assert mem_write with mem_wdata = req_wdata in ACCESS (C+1) and pulse rsp_valid in C+2.
REQ-024 SHALL, for SB/SH, read-modify-write: ACCESS (C+1) asserts mem_read and registers the word; WRITE (C+2) asserts mem_write with only the addressed lane replaced; rsp_valid in C+3.
REQ-025 SHALL never assert mem_read and mem_write in the same cycle; both 0 in IDLE and RESP.
REQ-026 SHALL drive mem_addr = {addr_reg[31:2],2'b00} in ACCESS and WRITE, 0 otherwise.
REQ-027 SHALL go RESP -> IDLE unconditionally; back-to-back requests therefore have minimum spacing of 2 cycles (fault), 3 (load/SW), 4 (SB/SH).
REQ-028 SHALL hold rsp_rdata and rsp_fault stable after RESP until the next RESP.

Reset
REQ-029 SHALL on rst_n = 0 immediately force state IDLE, rsp_valid 0, rsp_rdata 0, rsp_fault 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, req_ready 1 after release.
REQ-030 SHALL abandon an in-flight request on reset with no memory write issued after assertion and no response produced.

Structure
REQ-031 SHALL place the state enum and funct3 width/sign constants in shared package lsu_pkg.
REQ-032 SHALL implement lane extraction/extension and store-lane merge in one combinational sub-module lsu_align.

Verification
REQ-033 SHALL cover: memory word 0x80 = 0x8899AABB; LB addr 0x81 -> rsp_rdata 0xFFFFFFAA in C+2; LBU 0x81 -> 0x000000AA; LHU 0x82 -> 0x00008899.
REQ-034 SHALL cover: SB wdata 0x12 to 0x83 over word 0x8899AABB -> mem_write in C+2 with mem_wdata 0x1299AABB, rsp in C+3, no fault.
REQ-035 SHALL cover: LW addr 0x102 and SH addr 0x101 -> rsp_fault 1 in C+1, mem_read/mem_write never asserted.
REQ-036 SHALL cover: LW addr 0x400 (MEM_WORDS = 256) and load funct3 = 011 -> rsp_fault 1, no memory access.
REQ-037 SHALL cover: rst_n driven low during WRITE of SH -> mem_write drops immediately, target word unchanged, no rsp_valid, req_ready 1 after release.
REQ-038 SHALL cover: req_valid held high for 10 cycles with alternating SW/LW to 0x10 -> each accepted only in IDLE, LW returns last SW data.
